// File: rtl/fp64_pkg.sv
// Shared binary64 constants, FSM encoding and alignment helper for fp_adder_seq.
package fp64_pkg;

  localparam int          EXP_W   = 11;
  localparam int          FRAC_W  = 52;
  localparam int          EXP_MAX = 2047;
  localparam logic [63:0] QNAN    = 64'h7FF8000000000000;

  // Working mantissa layout: {carry, hidden, frac[51:0], G, R, S}
  localparam int WM_W = FRAC_W + 5;
  localparam logic [EXP_W-1:0] SHIFT_MAX = 11'd56;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ALIGN = 3'd1;
  localparam state_t S_ADD   = 3'd2;
  localparam state_t S_NORM  = 3'd3;
  localparam state_t S_ROUND = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  // Right shift that folds every bit pushed past S back into S.
  function automatic logic [WM_W-1:0] shr_sticky(input logic [WM_W-1:0] v,
                                                 input logic [EXP_W-1:0] amt);
    logic [5:0]      sh;
    logic [WM_W-1:0] one;
    logic [WM_W-1:0] mask;
    sh   = (amt > SHIFT_MAX) ? SHIFT_MAX[5:0] : amt[5:0];
    one  = {{(WM_W-1){1'b0}}, 1'b1};
    mask = (one << sh) - one;
    return (v >> sh) | {{(WM_W-1){1'b0}}, |(v & mask)};
  endfunction

endpackage

// File: rtl/fp64_round_rne.sv
// Round-to-nearest-even of a normalised working mantissa into a packed binary64.
module fp64_round_rne
  import fp64_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W:0]    exp_in,
  input  logic [WM_W-2:0]   mant,
  output logic [63:0]       result
);

  localparam logic [EXP_W:0] EXP_LIM = EXP_MAX[EXP_W:0];

  logic              inc;
  logic              carry;
  logic [FRAC_W:0]   sig;
  logic [FRAC_W-1:0] frac;
  logic [EXP_W:0]    exp_adj;

  // NOTE: every combinational output is assigned on every path, so no latch is inferred.
  always_comb begin
    inc          = mant[2] & (mant[1] | mant[0] | mant[3]);
    {carry, sig} = {1'b0, mant[WM_W-2:3]} + {{(FRAC_W+1){1'b0}}, inc};
    // A carry-out leaves sig all-zero, so taking the upper bits is the 1-bit renormalise.
    frac         = carry ? sig[FRAC_W:1] : sig[FRAC_W-1:0];
    exp_adj      = exp_in + {{EXP_W{1'b0}}, carry};
    if (exp_adj >= EXP_LIM)
      result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else
      result = {sign, exp_adj[EXP_W-1:0], frac};
  end

endmodule

// File: rtl/fp_adder_seq.sv
// Multi-cycle binary64 adder: IDLE -> ALIGN -> ADD -> NORM* -> ROUND -> DONE.
// Define FP_ADDER_SPECIAL_EN to short-circuit Inf/NaN operands from ALIGN to DONE.
module fp_adder_seq
  import fp64_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] result,
  output logic        out_valid,
  input  logic        out_ready
);

  state_t          state;
  logic [63:0]     a_q, b_q;
  logic [WM_W-1:0] ma, mb;
  logic [EXP_W:0]  exp_q;
  logic            sign_q;
  logic [63:0]     round_result;

  logic [EXP_W-1:0] ea, eb, exp_al;
  logic [WM_W-1:0]  ma_init, mb_init, ma_al, mb_al;
  logic [WM_W-1:0]  sum;
  logic             sum_sign;
  logic             norm_carry, norm_shift;

  assign in_ready   = (state == S_IDLE);
  assign norm_carry = ma[WM_W-1];
  assign norm_shift = !ma[WM_W-2] && (exp_q != '0);

  always_comb begin
    ea      = a_q[62:52];
    eb      = b_q[62:52];
    ma_init = {2'b01, a_q[FRAC_W-1:0], 3'b000};
    mb_init = {2'b01, b_q[FRAC_W-1:0], 3'b000};
    if (ea >= eb) begin
      ma_al  = ma_init;
      mb_al  = shr_sticky(mb_init, ea - eb);
      exp_al = ea;
    end else begin
      ma_al  = shr_sticky(ma_init, eb - ea);
      mb_al  = mb_init;
      exp_al = eb;
    end
  end

  // Magnitude add/subtract; A's sign wins an exact tie.
  always_comb begin
    sum_sign = a_q[63];
    if (a_q[63] == b_q[63]) begin
      sum = ma + mb;
    end else if (ma >= mb) begin
      sum = ma - mb;
    end else begin
      sum      = mb - ma;
      sum_sign = b_q[63];
    end
  end

`ifdef FP_ADDER_SPECIAL_EN
  logic        a_inf, b_inf, a_nan, b_nan, special;
  logic [63:0] special_result;

  always_comb begin
    a_nan   = (&ea) && (|a_q[FRAC_W-1:0]);
    b_nan   = (&eb) && (|b_q[FRAC_W-1:0]);
    a_inf   = (&ea) && !(|a_q[FRAC_W-1:0]);
    b_inf   = (&eb) && !(|b_q[FRAC_W-1:0]);
    special = (&ea) || (&eb);
    if (a_nan || b_nan || (a_inf && b_inf && (a_q[63] != b_q[63])))
      special_result = QNAN;
    else if (a_inf)
      special_result = a_q;
    else
      special_result = b_q;
  end
`endif

  fp64_round_rne u_round (
    .sign   (sign_q),
    .exp_in (exp_q),
    .mant   (ma[WM_W-2:0]),
    .result (round_result)
  );

  // NOTE: sequential state uses <= so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        S_IDLE:  if (in_valid) state <= S_ALIGN;
        S_ALIGN: begin
`ifdef FP_ADDER_SPECIAL_EN
          if (special) begin
            result <= special_result;
            state  <= S_DONE;
          end else begin
            state <= S_ADD;
          end
`else
          state <= S_ADD;
`endif
        end
        S_ADD:   state <= S_NORM;
        S_NORM:  if (norm_carry || !norm_shift) state <= S_ROUND;
        S_ROUND: begin
          result    <= round_result;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          // The special path enters with out_valid low and raises it here one cycle later.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; they are always written before being consumed.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (in_valid) begin
        a_q <= A;
        b_q <= B;
      end
      S_ALIGN: begin
        ma    <= ma_al;
        mb    <= mb_al;
        exp_q <= {1'b0, exp_al};
      end
      S_ADD: begin
        ma     <= sum;
        sign_q <= sum_sign;
        if (sum == '0) begin
          exp_q  <= '0;
          sign_q <= 1'b0;
        end
      end
      S_NORM: begin
        if (norm_carry) begin
          ma    <= {1'b0, ma[WM_W-1:2], ma[1] | ma[0]};
          exp_q <= exp_q + 1'b1;
        end else if (norm_shift) begin
          ma    <= ma << 1;
          exp_q <= exp_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
